// File: rtl/nn_result_fifo_if.sv
// ---------------------------------------------------------------------------
// nn_result_fifo_if
// Handshake/bus bundle between the network output stage, the result FIFO and
// the firmware read port.
//   Producer side : nn_result, nn_ready, threshold
//   Consumer side : pop, clr_ovf (in); rd_data, rd_class, empty, full,
//                   count, overflow (out)
// Optional macro NN_RESULT_TIMESTAMP_EN adds rd_tstamp[15:0] (head entry
// capture time).
// Modports: slave = FIFO view, master = driver/firmware view.
// ---------------------------------------------------------------------------
interface nn_result_fifo_if #(
    parameter int DEPTH = 8,
    parameter int W     = 32
);
    logic [W-1:0]            nn_result;
    logic                    nn_ready;
    logic [W-1:0]            threshold;
    logic                    pop;
    logic                    clr_ovf;
    logic [W-1:0]            rd_data;
    logic                    rd_class;
    logic                    empty;
    logic                    full;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
`ifdef NN_RESULT_TIMESTAMP_EN
    logic [15:0]             rd_tstamp;

    modport slave (
        input  nn_result, nn_ready, threshold, pop, clr_ovf,
        output rd_data, rd_class, empty, full, count, overflow, rd_tstamp
    );
    modport master (
        output nn_result, nn_ready, threshold, pop, clr_ovf,
        input  rd_data, rd_class, empty, full, count, overflow, rd_tstamp
    );
`else
    modport slave (
        input  nn_result, nn_ready, threshold, pop, clr_ovf,
        output rd_data, rd_class, empty, full, count, overflow
    );
    modport master (
        output nn_result, nn_ready, threshold, pop, clr_ovf,
        input  rd_data, rd_class, empty, full, count, overflow
    );
`endif
endinterface

// File: rtl/nn_result_fifo.sv
// ---------------------------------------------------------------------------
// nn_result_fifo
// Capture stage behind the network output sigmoid. Each rising edge of
// nn_ready pushes {class, nn_result} into a first-word-fall-through FIFO,
// where class = (nn_result >= threshold) under IEEE ordering (NaN -> 0).
// Firmware drains entries with pop; dropped results set a sticky overflow.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : nn_result_fifo_if.slave (see interface file for signal list)
// Optional macro NN_RESULT_TIMESTAMP_EN: free-running 16-bit cycle counter
// stored per entry and presented on bus.rd_tstamp.
// ---------------------------------------------------------------------------
module nn_result_fifo #(
    parameter int DEPTH      = 8,
    parameter int exp_width  = 8,
    parameter int mant_width = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    nn_result_fifo_if.slave      bus
);
    localparam int W  = exp_width + mant_width;
    localparam int FW = mant_width - 1;        // stored fraction bits
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef NN_RESULT_TIMESTAMP_EN
    localparam int EW = W + 1 + 16;
`else
    localparam int EW = W + 1;
`endif

    logic [EW-1:0] r_mem [DEPTH];
    logic          r_ready_d;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_empty;
    logic          r_full;

    logic          w_push_req;
    logic          w_pop_ok;
    logic          w_push_ok;
    logic          w_drop;
    logic          w_class;
    logic [CW-1:0] w_count_next;
    logic [EW-1:0] w_head;
    logic [EW-1:0] w_entry;

    // ---------------- classification (IEEE >=) ----------------
    logic             w_a_sign, w_b_sign, w_a_nan, w_b_nan, w_both_zero;
    logic [W-2:0]     w_a_mag, w_b_mag;

    assign w_a_sign    = bus.nn_result[W-1];
    assign w_b_sign    = bus.threshold[W-1];
    assign w_a_mag     = bus.nn_result[W-2:0];
    assign w_b_mag     = bus.threshold[W-2:0];
    assign w_a_nan     = (&bus.nn_result[W-2 -: exp_width]) && (|bus.nn_result[FW-1:0]);
    assign w_b_nan     = (&bus.threshold[W-2 -: exp_width]) && (|bus.threshold[FW-1:0]);
    // +0 and -0 compare equal regardless of sign bits
    assign w_both_zero = (w_a_mag == '0) && (w_b_mag == '0);

    always_comb begin
        w_class = 1'b0;
        if (w_a_nan || w_b_nan)
            w_class = 1'b0;
        else if (w_both_zero)
            w_class = 1'b1;
        else if (!w_a_sign && !w_b_sign)
            w_class = (w_a_mag >= w_b_mag);
        else if (!w_a_sign && w_b_sign)
            w_class = 1'b1;
        else if (w_a_sign && !w_b_sign)
            w_class = 1'b0;
        else
            w_class = (w_a_mag <= w_b_mag);   // both negative: reversed
    end

    // ---------------- push / pop arbitration ----------------
    assign w_push_req = bus.nn_ready & ~r_ready_d;
    assign w_pop_ok   = bus.pop & ~r_empty;
    // When full, a same-cycle pop frees the slot being written.
    assign w_push_ok  = w_push_req & (~r_full | w_pop_ok);
    assign w_drop     = w_push_req & r_full & ~w_pop_ok;

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok)
            w_count_next = r_count + 1'b1;
        else if (w_pop_ok && !w_push_ok)
            w_count_next = r_count - 1'b1;
    end

`ifdef NN_RESULT_TIMESTAMP_EN
    logic [15:0] r_tstamp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tstamp <= '0;
        else
            r_tstamp <= r_tstamp + 16'd1;
    end

    assign w_entry       = {r_tstamp, w_class, bus.nn_result};
    assign bus.rd_tstamp = r_empty ? 16'd0 : w_head[W+16:W+1];
`else
    assign w_entry = {w_class, bus.nn_result};
`endif

    // ---------------- control state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready_d  <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
        end else begin
            r_ready_d <= bus.nn_ready;
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == CW'(DEPTH));
            // set has priority over clear
            if (w_drop)
                r_overflow <= 1'b1;
            else if (bus.clr_ovf)
                r_overflow <= 1'b0;
        end
    end

    // Storage is not reset; reads are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= w_entry;
    end

    assign w_head = r_mem[r_rd_ptr];

    assign bus.rd_data  = r_empty ? '0   : w_head[W-1:0];
    assign bus.rd_class = r_empty ? 1'b0 : w_head[W];
    assign bus.empty    = r_empty;
    assign bus.full     = r_full;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_nn_result_fifo.sv
module tb_nn_result_fifo;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    nn_result_fifo_if #(.DEPTH(8), .W(32)) bus ();

    nn_result_fifo #(.DEPTH(8), .exp_width(8), .mant_width(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pulse(input logic [31:0] val);
        bus.nn_result = val;
        bus.nn_ready  = 1'b1;
        tick();
        bus.nn_ready  = 1'b0;
        tick();
        $display("push data=%08h count=%0d overflow=%0b", val, bus.count, bus.overflow);
    endtask

    task automatic pop_one();
        $display("pop  data=%08h class=%0b", bus.rd_data, bus.rd_class);
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.nn_result = '0; bus.nn_ready = 0; bus.threshold = '0;
        bus.pop = 0; bus.clr_ovf = 0;
        rst = 1'b1;
        #2;
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", bus.overflow); end
        checks++; if (bus.rd_data !== 32'h0 || bus.rd_class !== 1'b0) begin errors++;
            $display("FAIL reset_rd got=%08h/%0b exp=00000000/0", bus.rd_data, bus.rd_class); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_capture();
        bus.threshold = 32'h3F000000;
        bus.nn_result = 32'h3F400000;
        bus.nn_ready  = 1'b1;
        tick();
        checks++; if (bus.count !== 4'd1 || bus.rd_data !== 32'h3F400000) begin errors++;
            $display("FAIL single_latency got=%0d/%08h exp=1/3f400000", bus.count, bus.rd_data); end
        for (int i = 0; i < 9; i++) tick();
        bus.nn_ready = 1'b0;
        tick();
        $display("push data=3f400000 count=%0d (level held 10 cycles)", bus.count);
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", bus.count); end
        checks++; if (bus.rd_data !== 32'h3F400000) begin errors++; $display("FAIL single_data got=%08h exp=3f400000", bus.rd_data); end
        checks++; if (bus.rd_class !== 1'b1) begin errors++; $display("FAIL single_class got=%0b exp=1", bus.rd_class); end
        pop_one();
        checks++; if (bus.empty !== 1'b1 || bus.rd_data !== 32'h0) begin errors++;
            $display("FAIL single_drain got=%0b/%08h exp=1/00000000", bus.empty, bus.rd_data); end
    endtask

    task automatic test_threshold();
        logic [31:0] res_tab [8];
        logic [31:0] thr_tab [8];
        logic        exp_tab [8];
        res_tab = '{32'h3F000000, 32'h3EFFFFFF, 32'h7FC00000, 32'hBF800000,
                    32'hC0000000, 32'h80000000, 32'h3F000000, 32'hBF800000};
        thr_tab = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'hC0000000,
                    32'hBF800000, 32'h00000000, 32'h7F800001, 32'h3F000000};
        exp_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            bus.threshold = thr_tab[i];
            push_pulse(res_tab[i]);
            checks++; if (bus.rd_data !== res_tab[i] || bus.rd_class !== exp_tab[i]) begin errors++;
                $display("FAIL class_%0d got=%08h/%0b exp=%08h/%0b", i, bus.rd_data, bus.rd_class, res_tab[i], exp_tab[i]); end
            pop_one();
        end
        bus.threshold = 32'h3F000000;
    endtask

    task automatic test_fill_overflow();
        logic [31:0] v [10];
        v = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
              32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
        for (int i = 0; i < 8; i++) push_pulse(v[i]);
        checks++; if (bus.full !== 1'b1 || bus.count !== 4'd8 || bus.overflow !== 1'b0) begin errors++;
            $display("FAIL fill_full got=%0b/%0d/%0b exp=1/8/0", bus.full, bus.count, bus.overflow); end
        push_pulse(v[8]);
        checks++; if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin errors++;
            $display("FAIL fill_drop got=%0b/%0d exp=1/8", bus.overflow, bus.count); end
        // drop and clear in the same cycle: set wins
        bus.clr_ovf = 1'b1;
        bus.nn_result = v[9];
        bus.nn_ready = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        bus.nn_ready = 1'b0;
        tick();
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%0b exp=1", bus.overflow); end
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", bus.overflow); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.rd_data !== v[i]) begin errors++;
                $display("FAIL fill_read_%0d got=%08h exp=%08h", i, bus.rd_data, v[i]); end
            pop_one();
        end
        checks++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin errors++;
            $display("FAIL fill_empty got=%0b/%0d exp=1/0", bus.empty, bus.count); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 8; i++) push_pulse(32'h40000000 + i);
        bus.pop = 1'b1;
        bus.nn_result = 32'h41200000;
        bus.nn_ready = 1'b1;
        tick();
        bus.pop = 1'b0;
        bus.nn_ready = 1'b0;
        $display("push+pop data=41200000 count=%0d", bus.count);
        checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin errors++;
            $display("FAIL fullpp_state got=%0d/%0b/%0b exp=8/1/0", bus.count, bus.full, bus.overflow); end
        checks++; if (bus.rd_data !== 32'h40000002) begin errors++;
            $display("FAIL fullpp_head got=%08h exp=40000002", bus.rd_data); end
        for (int i = 0; i < 7; i++) pop_one();
        checks++; if (bus.rd_data !== 32'h41200000 || bus.count !== 4'd1) begin errors++;
            $display("FAIL fullpp_last got=%08h/%0d exp=41200000/1", bus.rd_data, bus.count); end
        pop_one();
    endtask

    task automatic test_empty_cases();
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin errors++;
            $display("FAIL pop_empty got=%0d/%0b exp=0/1", bus.count, bus.empty); end
        bus.pop = 1'b1;
        bus.nn_result = 32'hC1000000;
        bus.nn_ready = 1'b1;
        tick();
        bus.pop = 1'b0;
        bus.nn_ready = 1'b0;
        tick();
        checks++; if (bus.count !== 4'd1 || bus.rd_data !== 32'hC1000000 || bus.rd_class !== 1'b0) begin errors++;
            $display("FAIL pushpop_empty got=%0d/%08h/%0b exp=1/c1000000/0", bus.count, bus.rd_data, bus.rd_class); end
        pop_one();
    endtask

    task automatic test_reset_mid();
        push_pulse(32'h3F800000);
        push_pulse(32'h40000000);
        push_pulse(32'h40400000);
        checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL mid_pre got=%0d exp=3", bus.count); end
        bus.nn_result = 32'h40800000;
        bus.nn_ready = 1'b1;
        do_reset();
        checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0) begin errors++;
            $display("FAIL mid_reset got=%0d/%0b/%0b exp=0/1/0", bus.count, bus.empty, bus.overflow); end
        tick();
        checks++; if (bus.count !== 4'd1 || bus.rd_data !== 32'h40800000) begin errors++;
            $display("FAIL mid_release got=%0d/%08h exp=1/40800000", bus.count, bus.rd_data); end
        for (int i = 0; i < 3; i++) tick();
        bus.nn_ready = 1'b0;
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL mid_single got=%0d exp=1", bus.count); end
        pop_one();
    endtask

`ifdef NN_RESULT_TIMESTAMP_EN
    task automatic test_timestamp();
        bus.nn_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            bus.nn_result = 32'h3F800000 + c;
            bus.nn_ready  = (c == 5 || c == 20);
            tick();
        end
        bus.nn_ready = 1'b0;
        checks++; if (bus.rd_tstamp !== 16'd5) begin errors++; $display("FAIL tstamp_first got=%0d exp=5", bus.rd_tstamp); end
        pop_one();
        checks++; if (bus.rd_tstamp !== 16'd20) begin errors++; $display("FAIL tstamp_second got=%0d exp=20", bus.rd_tstamp); end
        pop_one();
        checks++; if (bus.rd_tstamp !== 16'd0) begin errors++; $display("FAIL tstamp_empty got=%0d exp=0", bus.rd_tstamp); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_capture();
        test_threshold();
        test_fill_overflow();
        test_full_push_pop();
        test_empty_cases();
        test_reset_mid();
`ifdef NN_RESULT_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
